// File: rtl/bsg_frame_loopback_tester.sv
// Loopback traffic generator/checker: issues numbered packets toward a remote node
// and checks that they come back in order with source/destination ids swapped.
module bsg_frame_loopback_tester #(
  parameter int ring_width_p = 80,
  parameter int my_id_p      = 0,
  parameter int target_id_p  = 1,
  parameter int num_pkts_p   = 16,
  parameter int max_out_p    = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [7:0]              err_cnt_o,
  output logic [15:0]             recv_cnt_o
);

  localparam int          PW       = ring_width_p - 8;
  localparam logic [3:0]  MY_ID    = 4'(my_id_p);
  localparam logic [3:0]  TGT_ID   = 4'(target_id_p);
  localparam logic [15:0] NUM_PKTS = 16'(num_pkts_p);
  localparam logic [3:0]  MAX_OUT  = 4'(max_out_p);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // Payload is the 16-bit counter zero-extended or truncated to the payload field.
  function automatic logic [ring_width_p-1:0] make_pkt(input logic [3:0] dest,
                                                       input logic [3:0] src,
                                                       input logic [15:0] cnt);
    logic [PW+15:0] ext;
    ext = {{PW{1'b0}}, cnt};
    return {dest, src, ext[PW-1:0]};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Assertion is asynchronous; release is delayed two clocks so the first start
  // can only be seen once every flop is cleanly out of reset.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n   = rst_sync[1];
  assign ready_o = rst_n;

  state_e      state, state_n;
  logic [15:0] send_cnt, send_n, recv_n;
  logic [3:0]  outstanding, out_next;
  logic [7:0]  err_n;
  logic        error_n;
  logic        accept, rx, rx_valid, rx_bad;

  assign accept   = v_o & yumi_i;
  assign rx       = v_i & ready_o;
  assign rx_valid = rx && (outstanding != 4'd0);
  assign rx_bad   = rx && ((outstanding == 4'd0) ||
                           (data_i != make_pkt(MY_ID, TGT_ID, recv_cnt_o)));
  assign out_next = outstanding + 4'(accept) - 4'(rx_valid);

  always_comb begin
    state_n = state;
    send_n  = send_cnt;
    recv_n  = recv_cnt_o;
    err_n   = err_cnt_o;
    error_n = error_o;
    if (rx_valid) recv_n = recv_cnt_o + 16'd1;
    if (rx_bad) begin
      err_n   = sat_inc8(err_cnt_o);
      error_n = 1'b1;
    end
    if (accept) send_n = send_cnt + 16'd1;
    case (state)
      IDLE, DONE: if (start_i) begin
        state_n = RUN;
        send_n  = 16'd0;
        recv_n  = 16'd0;
        err_n   = 8'd0;
        error_n = 1'b0;
      end
      RUN:     if (accept && (send_n == NUM_PKTS)) state_n = DRAIN;
      DRAIN:   if (out_next == 4'd0) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values; v_o/data_o only move on
  // acceptance, so an offered packet stays stable until taken.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      send_cnt    <= 16'd0;
      outstanding <= 4'd0;
      recv_cnt_o  <= 16'd0;
      err_cnt_o   <= 8'd0;
      error_o     <= 1'b0;
      done_o      <= 1'b0;
      v_o         <= 1'b0;
      data_o      <= '0;
    end else begin
      state       <= state_n;
      send_cnt    <= send_n;
      outstanding <= out_next;
      recv_cnt_o  <= recv_n;
      err_cnt_o   <= err_n;
      error_o     <= error_n;
      done_o      <= (state_n == DONE);
      v_o         <= (state_n == RUN) && (out_next < MAX_OUT);
      data_o      <= make_pkt(TGT_ID, MY_ID, send_n);
    end
  end

endmodule

// File: tb/tb_bsg_frame_loopback_tester.sv
// Directed bench for bsg_frame_loopback_tester with a behavioural loopback node
// (2-cycle response latency, optional stall, corruption and unsolicited injection).
module tb_bsg_frame_loopback_tester;

  logic        clk = 1'b0;
  logic        reset_n, start, yumi_i, v_i;
  logic        v_o, ready_o, done_o, error_o;
  logic [79:0] data_o, data_i;
  logic [7:0]  err_cnt_o;
  logic [15:0] recv_cnt_o;

  always #5 clk = ~clk;

  bsg_frame_loopback_tester dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .done_o(done_o), .error_o(error_o), .err_cnt_o(err_cnt_o), .recv_cnt_o(recv_cnt_o)
  );

  // Controls written only by the stimulus block
  logic yumi_en, resp_en;
  int   corrupt_idx, hold_req, inj_req;
  // State written only by the loopback model
  logic        s0_v = 1'b0, s1_v = 1'b0, holding, hold_stable = 1'b1;
  logic [79:0] s0_d = '0, s1_d = '0, hold_snap = '0;
  int          sent = 0, hold_seen = 0, inj_done = 0, hdr_bad = 0;
  logic [31:0] log_q[$];

  int total = 0, passed = 0, failed = 0;
  int base, sent0;
  logic seq_ok;

  initial begin
    yumi_i = 1'b0; v_i = 1'b0; data_i = '0;
  end

  always @(negedge clk) begin
    holding = yumi_en && v_o && (hold_seen < hold_req) && (data_o[71:0] == 72'd3);
    if (holding) begin
      if (hold_seen == 0) hold_snap = data_o;
      else if (data_o !== hold_snap) hold_stable = 1'b0;
      hold_seen++;
    end
    yumi_i = yumi_en && v_o && !holding;
    v_i    = s1_v;
    data_i = s1_d;
    s1_v   = s0_v;
    s1_d   = s0_d;
    s0_v   = 1'b0;
    if (v_o && yumi_i) begin
      log_q.push_back(data_o[31:0]);
      sent++;
      if (data_o[79:72] !== 8'h10) hdr_bad++;
      if (resp_en) begin
        s0_v = 1'b1;
        s0_d = {4'h0, 4'h1, (data_o[71:0] == 72'(corrupt_idx)) ? 72'h9 : data_o[71:0]};
      end
    end
    if (inj_done < inj_req) begin
      v_i    = 1'b1;
      data_i = {4'h0, 4'h1, 72'hABC};
      inj_done++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_o !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic check_seq(input string tag);
    seq_ok = (log_q.size() - base == 16);
    for (int i = 0; i < 16 && seq_ok; i++)
      if (log_q[base + i] != 32'(i)) seq_ok = 1'b0;
    check(tag, 32'(seq_ok), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; yumi_en = 1'b0; resp_en = 1'b0;
    corrupt_idx = -1; hold_req = 0; inj_req = 0;
    repeat (3) @(negedge clk);
    check("rst_v_o",     32'(v_o),        32'd0);
    check("rst_ready",   32'(ready_o),    32'd0);
    check("rst_done",    32'(done_o),     32'd0);
    check("rst_error",   32'(error_o),    32'd0);
    check("rst_err_cnt", 32'(err_cnt_o),  32'd0);
    check("rst_recv",    32'(recv_cnt_o), 32'd0);

    // Release, then offer a start while the synchronizer is still holding reset
    reset_n = 1'b1;
    @(negedge clk);
    check("sync_ready_low", 32'(ready_o), 32'd0);
    pulse_start();
    @(negedge clk);
    check("early_start_ignored", 32'(v_o), 32'd0);
    check("ready_high", 32'(ready_o), 32'd1);

    // Unsolicited response in IDLE
    inj_req = 1;
    repeat (3) @(negedge clk);
    check("unsol_err_cnt", 32'(err_cnt_o),  32'd1);
    check("unsol_recv",    32'(recv_cnt_o), 32'd0);
    check("unsol_error",   32'(error_o),    32'd1);
    check("unsol_done",    32'(done_o),     32'd0);

    // Ideal loopback run
    yumi_en = 1'b1; resp_en = 1'b1;
    base = log_q.size(); sent0 = sent;
    pulse_start();
    check("run_error_cleared", 32'(error_o), 32'd0);
    wait_done();
    check("ideal_done",    32'(done_o),     32'd1);
    check("ideal_error",   32'(error_o),    32'd0);
    check("ideal_err_cnt", 32'(err_cnt_o),  32'd0);
    check("ideal_recv",    32'(recv_cnt_o), 32'd16);
    check("ideal_sent",    32'(sent - sent0), 32'd16);
    check_seq("ideal_seq");

    // Stall packet 3 for five cycles
    hold_req = 5;
    base = log_q.size(); sent0 = sent;
    pulse_start();
    wait_done();
    check("hold_cycles", 32'(hold_seen),   32'd5);
    check("hold_stable", 32'(hold_stable), 32'd1);
    check_seq("hold_seq");
    check("hold_recv",   32'(recv_cnt_o), 32'd16);
    check("hold_error",  32'(error_o),    32'd0);

    // Corrupt returned payload 5
    corrupt_idx = 5;
    pulse_start();
    wait_done();
    corrupt_idx = -1;
    check("corrupt_error",   32'(error_o),    32'd1);
    check("corrupt_err_cnt", 32'(err_cnt_o),  32'd1);
    check("corrupt_recv",    32'(recv_cnt_o), 32'd16);
    check("corrupt_done",    32'(done_o),     32'd1);

    // 300 unsolicited responses in DONE saturate the error counter
    inj_req = inj_req + 300;
    repeat (310) @(negedge clk);
    check("sat_err_cnt", 32'(err_cnt_o),  32'd255);
    check("sat_recv",    32'(recv_cnt_o), 32'd16);
    check("sat_done",    32'(done_o),     32'd1);

    // Loopback silent: issue stops at max outstanding
    resp_en = 1'b0;
    sent0 = sent;
    pulse_start();
    repeat (30) @(negedge clk);
    check("silent_sent",    32'(sent - sent0), 32'd4);
    check("silent_v_o",     32'(v_o),          32'd0);
    check("silent_done",    32'(done_o),       32'd0);
    check("silent_recv",    32'(recv_cnt_o),   32'd0);
    check("silent_err_cnt", 32'(err_cnt_o),    32'd0);

    // Recover, then reset mid-run once packet 7 is accepted
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    resp_en = 1'b1;
    sent0 = sent;
    pulse_start();
    for (int i = 0; i < 100 && (sent - sent0) < 8; i++) @(negedge clk);
    check("midrun_reached_pkt7", 32'(sent - sent0), 32'd8);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_v_o",     32'(v_o),        32'd0);
    check("async_ready",   32'(ready_o),    32'd0);
    check("async_done",    32'(done_o),     32'd0);
    check("async_error",   32'(error_o),    32'd0);
    check("async_err_cnt", 32'(err_cnt_o),  32'd0);
    check("async_recv",    32'(recv_cnt_o), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle_v_o", 32'(v_o), 32'd0);
    base = log_q.size(); sent0 = sent;
    pulse_start();
    wait_done();
    check("clean_done",  32'(done_o),     32'd1);
    check("clean_error", 32'(error_o),    32'd0);
    check("clean_recv",  32'(recv_cnt_o), 32'd16);
    check_seq("clean_seq");
    check("header_ids",  32'(hdr_bad),    32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bsg_frame_loopback_tester.md
BSG_FRAME_LOOPBACK_TESTER -- requirements
Module: bsg_frame_loopback_tester

Interface
REQ-001 SHALL have parameter ring_width_p, default 80, packet width in bits (minimum 16).
REQ-002 SHALL have parameter my_id_p, default 0, 4-bit node id placed in srcid of issued packets.
REQ-003 SHALL have parameter target_id_p, default 1, 4-bit id of the loopback node addressed.
REQ-004 SHALL have parameter num_pkts_p, default 16, packets per test run (1..65535).
REQ-005 SHALL have parameter max_out_p, default 4, maximum outstanding (sent, unreturned) packets (1..15).
REQ-006 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start_i  input  1  one-cycle pulse starting a run.
REQ-009 SHALL have ports v_o output 1, data_o output ring_width_p, yumi_i input 1  packet issue toward the ring.
REQ-010 SHALL have ports v_i input 1, data_i input ring_width_p, ready_o output 1  returned packets from the ring.
REQ-011 SHALL have ports done_o output 1, error_o output 1, err_cnt_o output 8, recv_cnt_o output 16  status.

Function
REQ-012 Packet format SHALL be: destid = data[W-1:W-4], srcid = data[W-5:W-8], payload = data[W-9:0] (W = ring_width_p).
REQ-013 FSM SHALL have states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-014 IDLE -> RUN on start_i; DONE -> RUN on start_i; start_i ignored in RUN/DRAIN.
REQ-015 Entering RUN SHALL clear send count, recv_cnt_o, err_cnt_o, error_o, done_o.
REQ-016 RUN -> DRAIN in the cycle the num_pkts_p-th packet is accepted (v_o & yumi_i); DRAIN -> DONE when outstanding reaches 0.
REQ-017 Packet k (k = 0..num_pkts_p-1) SHALL carry destid=target_id_p, srcid=my_id_p, payload = k zero-extended/truncated to W-8 bits.
REQ-018 v_o SHALL be 1 in RUN only when outstanding < max_out_p; otherwise 0.
REQ-019 Once v_o is asserted, v_o and data_o SHALL stay stable until yumi_i; yumi_i is only legal while v_o = 1.
REQ-020 Acceptance (v_o & yumi_i) SHALL increment send count and outstanding; next packet may issue the following cycle (1 packet/cycle max).
REQ-021 ready_o SHALL be 1 whenever out of reset; a packet is received when v_i & ready_o.
REQ-022 Received packet SHALL match expected: destid=my_id_p, srcid=target_id_p, payload = recv_cnt_o (in-order return).
REQ-023 Receipt SHALL increment recv_cnt_o and decrement outstanding (simultaneous send and receive: outstanding unchanged).
REQ-024 Mismatch SHALL set error_o (sticky until next start) and increment err_cnt_o, saturating at 255.
REQ-025 Receipt with outstanding = 0 (any state) SHALL count as mismatch and SHALL NOT change outstanding or recv_cnt_o.
REQ-026 done_o SHALL be 1 exactly while in DONE.
REQ-027 Payload counter SHALL wrap modulo 2^(W-8) for comparison when W-8 < 16.

Reset
REQ-028 reset_n_i low SHALL immediately force IDLE and v_o=0, ready_o=0, done_o=0, error_o=0, err_cnt_o=0, recv_cnt_o=0, outstanding=0, send count=0.
REQ-029 Reset mid-run SHALL abandon the run; packets returning after deassertion and before start are mismatches per REQ-025.
REQ-030 Deassertion SHALL be synchronized internally; first start_i honored no earlier than 2 cycles after deassertion.

Verification
REQ-031 Ideal loopback (yumi_i=1, response 2 cycles later, ids swapped) defaults -> 16 packets sent, recv_cnt_o=16, done_o=1, error_o=0, err_cnt_o=0.
REQ-032 Loopback never responds, max_out_p=4 -> exactly 4 packets accepted, v_o=0 thereafter, FSM stuck in RUN, done_o=0.
REQ-033 yumi_i withheld 5 cycles on packet 3 -> data_o payload=3 stable all 5 cycles, v_o held 1, no skipped/duplicated payload.
REQ-034 Response payload 5 corrupted to 0x9 -> error_o=1, err_cnt_o=1, recv_cnt_o=16, done_o=1.
REQ-035 Unsolicited v_i pulse in IDLE -> err_cnt_o=1, recv_cnt_o=0; 300 corrupted responses over repeated runs without start -> err_cnt_o saturates at 255.
REQ-036 reset_n_i pulsed low after packet 7 accepted -> all outputs zero asynchronously, FSM IDLE; new start_i -> clean run completes, error_o=0.
